glbl_cfg_bank: RTL and testbench

Parametrised global configuration register bank; next generation of the chip-level config block. Provides NUM_REGS generic 32-bit software registers with per-register reset value, write-protect and lock masks, plus a built-in interrupt status/mask/lock trio. Sits on the internal reg bus behind the wishbone-to-reg bridge. Drives flattened config outputs to the MAC clock control, chip-ID and peripheral blocks.

---
 rtl/glbl_cfg_pkg.sv | 29 ++
 rtl/glbl_cfg_reg.sv | 23 ++
 rtl/glbl_cfg_bank.sv | 146 ++++++++++++++
 tb/tb_glbl_cfg_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/glbl_cfg_pkg.sv
// Shared constants, register map offsets and decode/FSM types for the global config bank.
package glbl_cfg_pkg;

  localparam logic [31:0] CHIP_SIGNATURE    = 32'h4743_4642;
  localparam logic [31:0] CHIP_RELEASE_DATE = 32'h2024_0601;
  localparam logic [31:0] CHIP_REVISION     = 32'h0000_0002;

  // Word offsets of the built-in registers, relative to NUM_REGS
  localparam int unsigned IRQ_STAT_OFS = 0;
  localparam int unsigned IRQ_MASK_OFS = 1;
  localparam int unsigned LOCK_OFS     = 2;

  typedef enum logic [1:0] {
    ACC_OK,
    ACC_RO,
    ACC_LOCKED,
    ACC_UNMAPPED
  } acc_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } bus_state_t;

  function automatic logic [31:0] be_expand(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/glbl_cfg_reg.sv
// One 32-bit byte-enabled software register with synchronous active-high reset.
module glbl_cfg_reg #(
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge mclk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/glbl_cfg_bank.sv
// Global configuration register bank: generic registers, IRQ status/mask and a sticky LOCK bit,
// served over a cs/ack register bus with one commit per transaction.
module glbl_cfg_bank
  import glbl_cfg_pkg::*;
#(
  parameter int unsigned            NUM_REGS  = 12,
  parameter int unsigned            ADDR_W    = 8,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]    WR_MASK   = '1,
  parameter logic [NUM_REGS-1:0]    LOCK_MASK = '0,
  parameter int unsigned            NUM_IRQ   = 8
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     reg_cs,
  input  logic                     reg_wr,
  input  logic [ADDR_W-1:0]        reg_addr,
  input  logic [31:0]              reg_wdata,
  input  logic [3:0]               reg_be,
  output logic [31:0]              reg_rdata,
  output logic                     reg_ack,
  input  logic [NUM_IRQ-1:0]       hw_irq_evt,
  output logic [NUM_REGS*32-1:0]   cfg_out,
  output logic                     irq_out,
  output logic                     cfg_locked
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_STAT = IDX_W'(NUM_REGS + IRQ_STAT_OFS);
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(NUM_REGS + IRQ_MASK_OFS);
  localparam logic [IDX_W-1:0] IDX_LOCK = IDX_W'(NUM_REGS + LOCK_OFS);
  localparam logic [31:0] IRQ_VALID = 32'((64'd1 << NUM_IRQ) - 64'd1);

  bus_state_t          state_q, state_d;
  acc_t                acc;
  logic [IDX_W-1:0]    idx;
  logic                accept, commit;
  logic [31:0]         rd_val, wbe, stat_word, mask_q;
  logic [31:0]         cfg_q [NUM_REGS];
  logic [NUM_REGS-1:0] gen_we;
  logic                mask_we, lock_set, lock_q;
  logic [NUM_IRQ-1:0]  stat_q, stat_clr;
  logic                unused_addr_lsb;

  assign idx             = reg_addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^reg_addr[1:0];
  assign accept          = (state_q == ST_IDLE) && reg_cs;
  assign stat_word       = 32'(stat_q);
  assign cfg_locked      = lock_q;

  always_ff @(posedge mclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ACK always returns to IDLE, so a cs still held during the ack cycle is never re-accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (reg_cs) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_ack = (state_q == ST_ACK);
  end

  always_comb begin
    acc      = ACC_UNMAPPED;
    rd_val   = '0;
    gen_we   = '0;
    mask_we  = 1'b0;
    stat_clr = '0;
    lock_set = 1'b0;
    wbe      = reg_wdata & be_expand(reg_be);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_val = cfg_q[i];
        if (!WR_MASK[i])                   acc = ACC_RO;
        else if (lock_q && LOCK_MASK[i])   acc = ACC_LOCKED;
        else                               acc = ACC_OK;
      end
    end
    if (idx == IDX_STAT) begin
      rd_val = stat_word;
      acc    = ACC_OK;
    end
    if (idx == IDX_MASK) begin
      rd_val = mask_q;
      acc    = ACC_OK;
    end
    if (idx == IDX_LOCK) begin
      rd_val = {31'd0, lock_q};
      acc    = ACC_OK;
    end
    commit = accept && reg_wr && (acc == ACC_OK);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      gen_we[i] = commit && (idx == IDX_W'(i));
    end
    mask_we  = commit && (idx == IDX_MASK);
    if (commit && (idx == IDX_STAT)) stat_clr = wbe[NUM_IRQ-1:0];
    lock_set = commit && (idx == IDX_LOCK) && reg_be[0] && reg_wdata[0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      glbl_cfg_reg #(.RESET_VAL(RESET_VAL[32*gi +: 32])) u_reg (
        .mclk  (mclk),
        .reset (reset),
        .we    (gen_we[gi]),
        .be    (reg_be),
        .wdata (reg_wdata),
        .q     (cfg_q[gi])
      );
      assign cfg_out[32*gi +: 32] = cfg_q[gi];
    end
  endgenerate

  // Bits above NUM_IRQ are masked off on write so they stay zero
  glbl_cfg_reg #(.RESET_VAL('0)) u_irq_mask (
    .mclk  (mclk),
    .reset (reset),
    .we    (mask_we),
    .be    (reg_be),
    .wdata (reg_wdata & IRQ_VALID),
    .q     (mask_q)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      reg_rdata <= '0;
      stat_q    <= '0;
      lock_q    <= 1'b0;
      irq_out   <= 1'b0;
    end else begin
      if (accept) reg_rdata <= rd_val;
      stat_q  <= hw_irq_evt | (stat_q & ~stat_clr);
      lock_q  <= lock_q | lock_set;
      irq_out <= |(stat_word & mask_q);
    end
  end

endmodule

// File: tb/tb_glbl_cfg_bank.sv
// Scoreboard bench for glbl_cfg_bank: directed bus transactions queue expected read data,
// a negedge monitor pops and compares on every reg_ack.
module tb_glbl_cfg_bank;

  localparam int unsigned NREG = 12;
  localparam logic [NREG*32-1:0] TB_RESET_VAL = {256'd0, 32'h1234_5678, 96'd0};
  localparam logic [NREG-1:0]    TB_WR_MASK   = 12'hFFB;
  localparam logic [NREG-1:0]    TB_LOCK_MASK = 12'h002;

  localparam logic [7:0] A_STAT = 8'h30;
  localparam logic [7:0] A_MASK = 8'h34;
  localparam logic [7:0] A_LOCK = 8'h38;

  logic              mclk, reset, reg_cs, reg_wr;
  logic [7:0]        reg_addr;
  logic [31:0]       reg_wdata, reg_rdata;
  logic [3:0]        reg_be;
  logic              reg_ack, irq_out, cfg_locked;
  logic [7:0]        hw_irq_evt;
  logic [NREG*32-1:0] cfg_out;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } sb_t;

  sb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  glbl_cfg_bank #(
    .NUM_REGS  (NREG),
    .ADDR_W    (8),
    .RESET_VAL (TB_RESET_VAL),
    .WR_MASK   (TB_WR_MASK),
    .LOCK_MASK (TB_LOCK_MASK),
    .NUM_IRQ   (8)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .reg_cs     (reg_cs),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_be     (reg_be),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .hw_irq_evt (hw_irq_evt),
    .cfg_out    (cfg_out),
    .irq_out    (irq_out),
    .cfg_locked (cfg_locked)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge mclk) begin
    if (reg_ack) begin
      if (exp_q.size() == 0) begin
        chk("ack_without_request", {31'd0, reg_ack}, 32'd0);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        chk($sformatf("rdata@%02h", e.addr), reg_rdata, e.exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic txn(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp, input bit hold);
    bit got;
    sb_t e;
    e.addr = addr;
    e.exp  = exp;
    exp_q.push_back(e);
    reg_cs    = 1'b1;
    reg_wr    = wr;
    reg_addr  = addr;
    reg_wdata = wdata;
    reg_be    = be;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge mclk);
      #1;
      if (reg_ack) got = 1'b1;
    end
    if (!got) chk($sformatf("ack_timeout@%02h", addr), 32'd0, 32'd1);
    if (hold) begin
      @(posedge mclk);
      #1;
      chk("held_cs_no_reack", {31'd0, reg_ack}, 32'd0);
    end
    reg_cs = 1'b0;
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
    txn(1'b0, addr, 32'd0, 4'h0, exp, 1'b0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                    input logic [31:0] pre);
    txn(1'b1, addr, wdata, be, pre, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0;
    reg_wdata = '0; reg_be = '0; hw_irq_evt = '0;
    cyc(3);
    reset = 1'b0;

    chk("reset_ack", {31'd0, reg_ack}, 32'd0);
    chk("reset_rdata", reg_rdata, 32'd0);
    chk("reset_irq_out", {31'd0, irq_out}, 32'd0);
    chk("reset_locked", {31'd0, cfg_locked}, 32'd0);
    for (int i = 0; i < NREG; i++)
      chk($sformatf("reset_cfg%0d", i), cfg_out[32*i +: 32], TB_RESET_VAL[32*i +: 32]);

    rd(8'h00, 32'h0000_0000);
    rd(8'h0C, 32'h1234_5678);
    rd(8'h08, 32'h0000_0000);
    rd(A_STAT, 32'h0);
    rd(A_MASK, 32'h0);
    rd(A_LOCK, 32'h0);
    rd(8'h3C, 32'h0);
    rd(8'hFC, 32'h0);
    wr(8'h3C, 32'hFFFF_FFFF, 4'hF, 32'h0);
    rd(8'h3C, 32'h0);

    txn(1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b1);
    chk("be_write_cfg0", cfg_out[31:0], 32'h00BB_00DD);
    rd(8'h00, 32'h00BB_00DD);

    wr(8'h08, 32'hFFFF_FFFF, 4'hF, 32'h0);
    chk("ro_cfg2", cfg_out[95:64], 32'h0);
    rd(8'h08, 32'h0);

    wr(8'h0C, 32'hCAFE_0000, 4'b1100, 32'h1234_5678);
    rd(8'h0C, 32'hCAFE_5678);

    wr(8'h04, 32'h0000_0011, 4'hF, 32'h0);
    wr(A_LOCK, 32'h0000_0001, 4'h1, 32'h0);
    chk("lock_set", {31'd0, cfg_locked}, 32'd1);
    wr(8'h04, 32'h0000_0055, 4'hF, 32'h11);
    rd(8'h04, 32'h11);
    wr(8'h10, 32'h0000_0077, 4'hF, 32'h0);
    rd(8'h10, 32'h77);
    wr(A_LOCK, 32'h0, 4'hF, 32'h1);
    rd(A_LOCK, 32'h1);
    wr(A_LOCK, 32'hFFFF_FFFF, 4'hF, 32'h1);
    rd(A_LOCK, 32'h1);
    chk("lock_sticky", {31'd0, cfg_locked}, 32'd1);

    wr(A_MASK, 32'h0000_0F04, 4'hF, 32'h0);
    hw_irq_evt = 8'h04;
    cyc(1);
    hw_irq_evt = 8'h00;
    chk("irq_out_lag", {31'd0, irq_out}, 32'd0);
    cyc(1);
    chk("irq_out_set", {31'd0, irq_out}, 32'd1);
    rd(A_STAT, 32'h04);
    hw_irq_evt = 8'h04;
    wr(A_STAT, 32'h04, 4'hF, 32'h04);
    hw_irq_evt = 8'h00;
    rd(A_STAT, 32'h04);
    wr(A_STAT, 32'h04, 4'hF, 32'h04);
    rd(A_STAT, 32'h00);
    chk("irq_out_cleared", {31'd0, irq_out}, 32'd0);
    hw_irq_evt = 8'h20;
    cyc(1);
    hw_irq_evt = 8'h00;
    cyc(2);
    chk("irq_masked_off", {31'd0, irq_out}, 32'd0);
    rd(A_STAT, 32'h20);
    rd(A_MASK, 32'h04);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rst_unlock", {31'd0, cfg_locked}, 32'd0);
    chk("rst_cfg1", cfg_out[63:32], 32'h0);
    chk("rst_cfg3", cfg_out[127:96], 32'h1234_5678);
    chk("rst_irq_out", {31'd0, irq_out}, 32'd0);
    rd(A_STAT, 32'h0);

    wr(8'h00, 32'h0000_0099, 4'hF, 32'h0);
    chk("pre_reset_cfg0", cfg_out[31:0], 32'h99);
    reset = 1'b1;
    cyc(1);
    chk("mid_txn_reset_ack", {31'd0, reg_ack}, 32'd0);
    chk("mid_txn_reset_cfg0", cfg_out[31:0], 32'h0);
    reset = 1'b0;
    rd(8'h00, 32'h0);

    cyc(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
